rom_burst_arb: RTL
==================

ROM_BURST_ARB -- requirements
Module: rom_burst_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 16, ROM word width.
REQ-003 SHALL have parameter LEN_W, default 8, burst length field width.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  2  per-client burst request.
REQ-007 SHALL have port req_ready  out  2  per-client grant, one-hot, one-cycle pulse.
REQ-008 SHALL have port req_base  in  2*ADDR_W  per-client start address, client 0 in the low slice.
REQ-009 SHALL have port req_len  in  2*LEN_W  per-client beat count minus 1.
REQ-010 SHALL have port rom_addr  out  ADDR_W  address to the synchronous ROM, 1-cycle read latency.
REQ-011 SHALL have port rom_q  in  DATA_W  ROM read data, valid the cycle after rom_addr.
REQ-012 SHALL have port out_valid  out  1  output beat valid.
REQ-013 SHALL have port out_ready  in  1  downstream accepts a beat.
REQ-014 SHALL have port out_data  out  DATA_W  ROM word.
REQ-015 SHALL have port out_id  out  1  client that owns the beat.
REQ-016 SHALL have port out_last  out  1  final beat of the burst.

Function
REQ-017 SHALL implement FSM states IDLE, BURST and DRAIN.
REQ-018 IDLE: if any req_valid bit is high, SHALL grant one client, pulse its req_ready, latch base/len/id, and enter BURST next cycle.
REQ-019 Arbitration SHALL be round-robin: after a grant to client k, client 1-k wins the next tie.
REQ-020 A request handshake SHALL complete only when req_valid and req_ready are both high; req_ready SHALL never be high outside IDLE.
REQ-021 BURST: SHALL issue one address per cycle (base, base+1, ...) while credit exists, with credit = 2 - fifo_count - inflight > 0.
REQ-022 Address increment SHALL wrap modulo 2^ADDR_W; for example, base 8191 with len 1 yields 8191 then 0.
REQ-023 Each issued address SHALL write rom_q into a 2-entry FIFO one cycle later, tagged with id and last.
REQ-024 No beat SHALL be dropped or duplicated under any out_ready pattern.
REQ-025 After the address for beat len+1 is issued, the FSM SHALL move to DRAIN.
REQ-026 DRAIN SHALL return to IDLE in the cycle the last beat is accepted (out_valid & out_ready & out_last).
REQ-027 out_valid SHALL equal FIFO not empty; FIFO head SHALL drive out_data, out_id and out_last.
REQ-028 With out_ready held high, first-beat out_valid SHALL occur 3 cycles after the request handshake cycle, followed by 1 beat per cycle.
REQ-029 req_len=0 SHALL produce exactly 1 beat with out_last=1.
REQ-030 rom_addr SHALL hold its last value when not issuing.

Reset
REQ-031 In a rst cycle, the block SHALL enter IDLE, empty the FIFO, clear inflight, and set the round-robin pointer so that client 0 wins the first tie.
REQ-032 After reset: req_ready=0, out_valid=0, out_data=0, out_id=0, out_last=0, rom_addr=0.
REQ-033 Reset mid-burst SHALL discard all pending beats; no beat of the aborted burst SHALL appear afterwards.

Configuration
REQ-034 With ROM_BURST_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority with client 0 always winning ties, and no round-robin state.
REQ-035 Without ROM_BURST_ARB_FIXED_PRIO_EN defined, arbitration SHALL be round-robin per REQ-019.

Verification
REQ-036 Client 0 requests base=0, len=2, out_ready=1 -> rom_addr 0,1,2 on consecutive cycles; 3 beats equal ROM[0..2]; out_last on beat 3; out_id=0.
REQ-037 Both clients request from reset, each with len=0 -> client 0 is served first, then client 1; with the macro defined, client 0 wins again if it re-requests.
REQ-038 Client 1 requests base=8190, len=3 -> addresses 8190, 8191, 0, 1 in order.
REQ-039 Request len=7 with out_ready toggling 1,0,0,1,... -> exactly 8 beats in address order, FIFO never overflows, and inflight+count never exceeds 2.
REQ-040 rst asserted on the 3rd beat of a len=5 burst -> all outputs return to 0 the next cycle, and the next request streams from its own base only.
REQ-041 Request len=0 base=159 -> a single beat equal to ROM[159] with out_last=1, and the FSM is back in IDLE the cycle after acceptance.

Source files
------------

// File: rtl/rom_burst_arb.sv
// Two-client burst reader for a synchronous ROM: arbitrates, streams addresses, buffers beats in a 2-entry FIFO.
// Define ROM_BURST_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins ties) instead of round-robin.
module rom_burst_arb #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*ADDR_W-1:0] req_base,
  input  logic [2*LEN_W-1:0]  req_len,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_q,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_id,
  output logic                out_last
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t              state_q, state_d;
  logic                any_req, gnt_id, take;
  logic [ADDR_W-1:0]   addr_q, addr_d, hold_q, hold_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                id_q, id_d;
  logic                inflight_q, inflight_d, inf_last_q, inf_last_d;
  logic [DATA_W-1:0]   fifo_data_q [2];
  logic [1:0]          fifo_id_q, fifo_last_q;
  logic                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d, occ;
  logic                push, pop, issue, fifo_ne;

  assign any_req = |req_valid;
  assign take    = (state_q == IDLE) && any_req;

`ifdef ROM_BURST_ARB_FIXED_PRIO_EN
  always_comb gnt_id = ~req_valid[0];
`else
  logic rr_q, rr_d;

  always_comb begin
    gnt_id = (req_valid == 2'b11) ? rr_q : req_valid[1];
    rr_d   = take ? ~gnt_id : rr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`endif

  // Credit counts the beat leaving the FIFO this cycle so a ready sink sees one beat per cycle.
  assign fifo_ne = (count_q != 2'd0);
  assign pop     = fifo_ne && out_ready;
  assign push    = inflight_q;
  assign occ     = count_q + {1'b0, inflight_q};
  assign issue   = (state_q == BURST) && ((occ != 2'd2) || pop);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = BURST;
      BURST:   if (issue && (rem_q == '0)) state_d = DRAIN;
      DRAIN:   if (pop && fifo_last_q[rd_ptr_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = take ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    rom_addr  = issue ? addr_q : hold_q;
    out_valid = fifo_ne;
    out_data  = fifo_ne ? fifo_data_q[rd_ptr_q] : '0;
    out_id    = fifo_ne & fifo_id_q[rd_ptr_q];
    out_last  = fifo_ne & fifo_last_q[rd_ptr_q];
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no inferred latch).
  always_comb begin
    addr_d     = addr_q;
    rem_d      = rem_q;
    id_d       = id_q;
    hold_d     = hold_q;
    inflight_d = issue;
    inf_last_d = issue && (rem_q == '0);
    if (take) begin
      addr_d = gnt_id ? req_base[2*ADDR_W-1:ADDR_W] : req_base[ADDR_W-1:0];
      rem_d  = gnt_id ? req_len[2*LEN_W-1:LEN_W]    : req_len[LEN_W-1:0];
      id_d   = gnt_id;
    end
    if (issue) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - LEN_W'(1);
      hold_d = addr_q;
    end
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      hold_q     <= '0;
      rem_q      <= '0;
      id_q       <= 1'b0;
      inflight_q <= 1'b0;
      inf_last_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      hold_q     <= hold_d;
      rem_q      <= rem_d;
      id_q       <= id_d;
      inflight_q <= inflight_d;
      inf_last_q <= inf_last_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: FIFO storage is not reset; outputs are masked by the count, which is.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rom_q;
      fifo_id_q[wr_ptr_q]   <= id_q;
      fifo_last_q[wr_ptr_q] <= inf_last_q;
    end
  end

endmodule
